multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore-style FSM that sequences a multi-cycle MIPS-subset datapath: fetch, decode, execute, memory and writeback.
- Replaces the single-cycle combinational control decode.
- Drives all datapath mux selects and enables, waits on a memory-ready handshake, and produces a combined PC enable.
- Traps on unsupported opcodes and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
opcode  input  6  instruction[31:26] from instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory handshake; high when the current read/write completes this cycle
pc_en  output  1  PC register enable = pc_write | (pc_write_cond & zero)
ir_write  output  1  instruction register load
i_or_d  output  1  memory address mux: 0=PC, 1=ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_to_reg  output  1  register write-data mux: 0=ALUOut, 1=MDR
reg_dst  output  1  write-register mux: 0=rt, 1=rd
reg_write  output  1  register file write enable
alu_src_a  output  1  ALU A mux: 0=PC, 1=rs
alu_src_b  output  2  ALU B mux: 00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  output  2  00=add, 01=sub, 10=funct-field decode
pc_source  output  2  PC mux: 00=ALU result, 01=ALUOut, 10=jump target
trap  output  1  illegal-opcode trap flag
state_dbg  output  4  current state encoding
retired  output  CNT_W  count of completed instructions

Behaviour:
- Reset (async, any time including mid-instruction):
  - State returns to FETCH.
  - retired clears to 0; trap clears to 0.
  - While rst is high, every control output is 0, including mem_read and mem_write.
  - A memory access in flight is abandoned. No partial write may be re-issued.
- Outputs are combinational from registered state plus mem_ready. Only the FETCH enables depend on mem_ready.
- Unlisted outputs are 0 in each state.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, TRAP=12.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are asserted only when mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state by opcode:
    - 000000 -> R_EXEC
    - 100011 or 101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> I_EXEC
    - any other -> TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD for LW, MEM_WR for SW.
- MEM_RD:
  - Outputs: mem_read=1, i_or_d=1.
  - Holds until mem_ready=1, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEM_WR:
  - Outputs: mem_write=1, i_or_d=1.
  - Holds until mem_ready=1, then goes to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1.
  - pc_en=zero. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10. Goes to FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- TRAP:
  - trap=1 and all enables 0.
  - Absorbing: leaves only on rst.
- Cycle counts with mem_ready=1 throughout, including FETCH:
  - R-type 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4.
  - Each wait cycle adds 1 cycle.
- Retired counter:
  - Increments by 1 on the clock edge leaving MEM_WB, MEM_WR (with mem_ready=1), R_WB, BRANCH, JUMP or I_WB.
  - Wraps modulo 2^CNT_W.
  - Does not increment on entry to TRAP.
- mem_ready is ignored in every state except FETCH, MEM_RD and MEM_WR.
- mem_read and mem_write are never high in the same cycle.

Decomposition:
- Package ctl_pkg holds:
  - state_t enum (4-bit, encodings above).
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI.
  - ALU-op constants ALU_ADD, ALU_SUB, ALU_FUNCT.
  - alu_src_b and pc_source select constants.
- One sub-module, mc_output_decode: purely combinational, maps (state, mem_ready, zero) to the control bundle and pc_en.
- multicycle_controller keeps the state register, next-state logic, trap and counter.

Test Plan:
- rst pulsed mid-MEM_WR (mem_ready=0) -> all outputs 0 immediately (async); after release state_dbg=0, retired=0, first cycle mem_read=1.
- R-type opcode 000000, mem_ready=1 -> state sequence 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; retired 0->1 after 4 cycles.
- LW 100011 with mem_ready low 2 cycles in MEM_RD -> sequence 0,1,2,3,3,3,4,0; mem_read/i_or_d held 3 cycles; total 7 cycles; retired +1.
- BEQ 000100 with zero=1 then again with zero=0 -> pc_en=1 with pc_source=01 in state 8 the first time; pc_en=0 the second; both take 3 cycles and both increment retired.
- Opcode 111111 -> DECODE goes to TRAP (12); trap=1, no enables for 20 cycles, retired unchanged; rst clears trap.
- Counter preloaded (CNT_W=4) to 15 via 15 J instructions -> 16th J gives retired=0 (wrap).

Source files
------------

// File: rtl/ctl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ctl_pkg                                                              |
// | Shared state encoding, opcode and datapath select constants for the  |
// | multicycle controller.                                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ctl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Dispatch target out of DECODE; anything unrecognised traps.
  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_RTYPE:     decode_target = S_R_EXEC;
      OP_LW, OP_SW: decode_target = S_MEM_ADDR;
      OP_BEQ:       decode_target = S_BRANCH;
      OP_J:         decode_target = S_JUMP;
      OP_ADDI:      decode_target = S_I_EXEC;
      default:      decode_target = S_TRAP;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_output_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_output_decode                                                     |
// | Combinational map from controller state to datapath control bundle. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mc_output_decode
  import ctl_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_mem_ready,
  input  logic       i_zero,
  output logic       o_pc_en,
  output logic       o_ir_write,
  output logic       o_i_or_d,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_mem_to_reg,
  output logic       o_reg_dst,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_pc_source,
  output logic       o_trap
);

  logic w_pc_write;
  logic w_pc_write_cond;

  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    o_ir_write      = 1'b0;
    o_i_or_d        = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_reg_dst       = 1'b0;
    o_reg_write     = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = SRCB_RT;
    o_alu_op        = ALU_ADD;
    o_pc_source     = PCSRC_ALU;
    o_trap          = 1'b0;
    case (state_t'(i_state))
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = SRCB_FOUR;
        o_ir_write  = i_mem_ready;
        w_pc_write  = i_mem_ready;
      end
      S_DECODE:   o_alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR, S_I_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        o_mem_read = 1'b1;
        o_i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        o_mem_write = 1'b1;
        o_i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        o_reg_write = 1'b1;
        o_reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a     = 1'b1;
        o_alu_op        = ALU_SUB;
        o_pc_source     = PCSRC_ALUOUT;
        w_pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        w_pc_write  = 1'b1;
        o_pc_source = PCSRC_JUMP;
      end
      S_I_WB:  o_reg_write = 1'b1;
      S_TRAP:  o_trap      = 1'b1;
      default: ;
    endcase
  end

  assign o_pc_en = w_pc_write | (w_pc_write_cond & i_zero);

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_controller                                                |
// | Multi-cycle MIPS-subset control FSM with trap and retire counter.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module multicycle_controller
  import ctl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             trap,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next;
  logic             w_retire;
  logic [CNT_W-1:0] r_retired;
  logic [15:0]      w_ctl;

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE:   w_next = decode_target(opcode);
      S_MEM_ADDR: w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WR: begin
        if (mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_R_EXEC:   w_next = S_R_WB;
      S_I_EXEC:   w_next = S_I_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + C_ONE;
    end
  end

  mc_output_decode u_dec (
    .i_state      (r_state),
    .i_mem_ready  (mem_ready),
    .i_zero       (zero),
    .o_pc_en      (w_ctl[15]),
    .o_ir_write   (w_ctl[14]),
    .o_i_or_d     (w_ctl[13]),
    .o_mem_read   (w_ctl[12]),
    .o_mem_write  (w_ctl[11]),
    .o_mem_to_reg (w_ctl[10]),
    .o_reg_dst    (w_ctl[9]),
    .o_reg_write  (w_ctl[8]),
    .o_alu_src_a  (w_ctl[7]),
    .o_alu_src_b  (w_ctl[6:5]),
    .o_alu_op     (w_ctl[4:3]),
    .o_pc_source  (w_ctl[2:1]),
    .o_trap       (w_ctl[0])
  );

  // Reset forces the bundle low combinationally so an in-flight access drops at once.
  assign {pc_en, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
          reg_write, alu_src_a, alu_src_b, alu_op, pc_source, trap}
         = rst ? 16'h0000 : w_ctl;

  assign state_dbg = r_state;
  assign retired   = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multicycle_controller                                             |
// | Directed + randomized check of the controller against a path model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, trap;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_dbg;
  logic [3:0] retired;
  logic [15:0] dut_ctl;

  int n_vec;
  int n_err;
  int exp_ret;

  multicycle_controller #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .ir_write   (ir_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .trap       (trap),
    .state_dbg  (state_dbg),
    .retired    (retired)
  );

  assign dut_ctl = {pc_en, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
                    reg_write, alu_src_a, alu_src_b, alu_op, pc_source, trap};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control bundle for a state, taken straight from the per-state output table.
  function automatic logic [15:0] exp_ctl(input int st, input bit mr, input bit z);
    logic pe, irw, iod, mrd, mwr, m2r, rdst, rw, sa, tr;
    logic [1:0] sb, aop, ps;
    {pe, irw, iod, mrd, mwr, m2r, rdst, rw, sa, tr} = '0;
    sb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (st)
      0:  begin mrd = 1; sb = 2'b01; irw = mr; pe = mr; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mrd = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iod = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin sa = 1; aop = 2'b01; ps = 2'b01; pe = z; end
      9:  begin pe = 1; ps = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      12: tr = 1;
      default: ;
    endcase
    return {pe, irw, iod, mrd, mwr, m2r, rdst, rw, sa, sb, aop, ps, tr};
  endfunction

  task automatic check_all(input int st, input logic [15:0] ectl);
    n_vec++;
    assert (dut_ctl === ectl) else begin
      n_err++;
      $error("FAIL ctl st=%0d observed=%h expected=%h", st, dut_ctl, ectl);
    end
    n_vec++;
    assert (state_dbg === 4'(st)) else begin
      n_err++;
      $error("FAIL state observed=%0d expected=%0d", state_dbg, st);
    end
    n_vec++;
    assert (retired === 4'(exp_ret)) else begin
      n_err++;
      $error("FAIL retired st=%0d observed=%0d expected=%0d", st, retired, exp_ret);
    end
  endtask

  // One clock: drive inputs, check mid-cycle, advance past the edge.
  task automatic cyc(input int st, input bit mr, input bit z);
    mem_ready = mr;
    zero      = z;
    #3;
    check_all(st, exp_ctl(st, mr, z));
    @(posedge clk);
    #1;
  endtask

  // Whole instruction as a list of visited states with per-cycle mem_ready.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit z);
    int st_q[$];
    bit mr_q[$];
    opcode = op;
    for (int i = 0; i < fw; i++) begin st_q.push_back(0); mr_q.push_back(0); end
    st_q.push_back(0); mr_q.push_back(1);
    st_q.push_back(1); mr_q.push_back(1'($urandom));
    case (op)
      6'b000000: begin st_q.push_back(6); st_q.push_back(7); end
      6'b100011: begin
        st_q.push_back(2);
        for (int i = 0; i <= mw; i++) st_q.push_back(3);
        st_q.push_back(4);
      end
      6'b101011: begin
        st_q.push_back(2);
        for (int i = 0; i <= mw; i++) st_q.push_back(5);
      end
      6'b000100: st_q.push_back(8);
      6'b000010: st_q.push_back(9);
      default:   begin st_q.push_back(10); st_q.push_back(11); end
    endcase
    for (int i = mr_q.size(); i < st_q.size(); i++) begin
      if (st_q[i] == 3 || st_q[i] == 5)
        mr_q.push_back((i + 1 < st_q.size() && st_q[i+1] == st_q[i]) ? 1'b0 : 1'b1);
      else
        mr_q.push_back(1'($urandom));
    end
    for (int i = 0; i < st_q.size(); i++) cyc(st_q[i], mr_q[i], z);
    exp_ret = (exp_ret + 1) % 16;
  endtask

  task automatic async_reset_check();
    rst = 1'b1;
    #1;
    exp_ret = 0;
    check_all(0, 16'h0000);
    #2;
    mem_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] ops [6];
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;
    n_vec = 0; n_err = 0; exp_ret = 0;
    rst = 1'b1; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    #7;
    check_all(0, 16'h0000);
    #5;
    mem_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_instr(6'b000000, 0, 0, 1'b0);
    run_instr(6'b100011, 0, 2, 1'b0);
    run_instr(6'b000100, 0, 0, 1'b1);
    run_instr(6'b000100, 1, 0, 1'b0);
    run_instr(6'b101011, 2, 1, 1'b1);
    run_instr(6'b001000, 0, 0, 1'b0);

    for (int k = 0; k < 30; k++)
      run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom));

    // Abandon a store while it is still waiting on memory.
    opcode = 6'b101011;
    cyc(0, 1, 0);
    cyc(1, 1, 0);
    cyc(2, 1, 0);
    cyc(5, 0, 0);
    cyc(5, 0, 0);
    async_reset_check();
    run_instr(6'b000010, 0, 0, 1'b0);

    // Illegal opcode traps and stays trapped.
    opcode = 6'b111111;
    cyc(0, 1, 0);
    cyc(1, 1, 0);
    for (int k = 0; k < 20; k++) cyc(12, 1'($urandom), 1'($urandom));
    async_reset_check();

    for (int k = 0; k < 16; k++) run_instr(6'b000010, 0, 0, 1'($urandom));
    cyc(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
